// File: rtl/controle_vez_jogador.sv
// Turn controller for tic-tac-toe: whose turn it is, move count, per-turn timeout.
// Optional macro ALTERNA_INICIO_EN alternates the starting player between games.
//
// state  | meaning
// OCIOSO | no game running, display dash
// VEZ1   | waiting for player 1 to move
// VEZ2   | waiting for player 2 to move
// ERRO   | turn timed out, waiting for reconhece
// FIM    | game over, display holds the last mover
module controle_vez_jogador #(
    parameter int TIMEOUT = 5000,
    parameter int CW      = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       fim_jogo,
    input  logic       reconhece,
    output logic [1:0] jogador,
    output logic       timeout,
    output logic       vez_ativa,
    output logic [3:0] jogadas
);

    typedef enum logic [2:0] {OCIOSO, VEZ1, VEZ2, ERRO, FIM} estado_t;

    estado_t       estado, prox_estado, estado_inicial;
    logic [CW-1:0] contador, prox_contador;
    logic [3:0]    prox_jogadas;
    logic [1:0]    prox_jogador;

`ifdef ALTERNA_INICIO_EN
    logic primeiro;
    logic inicio_aceito;

    assign inicio_aceito  = iniciar && (estado != ERRO);
    assign estado_inicial = primeiro ? VEZ2 : VEZ1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            primeiro <= 1'b0;
        else if (inicio_aceito)
            primeiro <= ~primeiro;
    end
`else
    assign estado_inicial = VEZ1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= OCIOSO;
            contador  <= '0;
            jogadas   <= 4'd0;
            jogador   <= 2'b00;
            timeout   <= 1'b0;
            vez_ativa <= 1'b0;
        end else begin
            estado    <= prox_estado;
            contador  <= prox_contador;
            jogadas   <= prox_jogadas;
            jogador   <= prox_jogador;
            timeout   <= (prox_estado == ERRO) && (estado != ERRO);
            vez_ativa <= (prox_estado == VEZ1) || (prox_estado == VEZ2);
        end
    end

    // Counter only survives a cycle when we stay in the same VEZ with no move.
    always_comb begin
        prox_estado   = estado;
        prox_contador = '0;
        prox_jogadas  = jogadas;
        case (estado)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    prox_estado  = estado_inicial;
                    prox_jogadas = 4'd0;
                end
            end
            VEZ1, VEZ2: begin
                if (iniciar) begin
                    prox_estado  = estado_inicial;
                    prox_jogadas = 4'd0;
                end else if (jogada) begin
                    prox_jogadas = jogadas + 4'd1;
                    if (fim_jogo || (jogadas == 4'd8))
                        prox_estado = FIM;
                    else
                        prox_estado = (estado == VEZ1) ? VEZ2 : VEZ1;
                end else if (fim_jogo) begin
                    prox_estado = FIM;
                end else if (contador == CW'(TIMEOUT - 1)) begin
                    prox_estado = ERRO;
                end else begin
                    prox_contador = contador + CW'(1);
                end
            end
            ERRO: begin
                if (reconhece) begin
                    prox_estado  = OCIOSO;
                    prox_jogadas = 4'd0;
                end
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    // FIM is only reached from a VEZ, so the current code is the last mover.
    always_comb begin
        prox_jogador = jogador;
        case (prox_estado)
            OCIOSO:  prox_jogador = 2'b00;
            VEZ1:    prox_jogador = 2'b01;
            VEZ2:    prox_jogador = 2'b10;
            ERRO:    prox_jogador = 2'b11;
            default: prox_jogador = jogador;
        endcase
    end

endmodule

// File: tb/tb_controle_vez_jogador.sv
// Directed self-checking bench for controle_vez_jogador with TIMEOUT=10.
module tb_controle_vez_jogador;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       jogada = 1'b0;
    logic       fim_jogo = 1'b0;
    logic       reconhece = 1'b0;
    logic [1:0] jogador;
    logic       timeout;
    logic       vez_ativa;
    logic [3:0] jogadas;

    int   checks = 0;
    int   failures = 0;
    logic model_primeiro = 1'b0;
    logic [1:0] cur;
    logic [1:0] code;

    controle_vez_jogador #(.TIMEOUT(10), .CW(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .jogada    (jogada),
        .fim_jogo  (fim_jogo),
        .reconhece (reconhece),
        .jogador   (jogador),
        .timeout   (timeout),
        .vez_ativa (vez_ativa),
        .jogadas   (jogadas)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] start_code();
`ifdef ALTERNA_INICIO_EN
        return model_primeiro ? 2'b10 : 2'b01;
`else
        return 2'b01;
`endif
    endfunction

    task automatic start_game(output logic [1:0] c);
        c = start_code();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        model_primeiro = ~model_primeiro;
        check("start_jogador", {2'b00, jogador}, {2'b00, c});
        check("start_jogadas", jogadas, 4'd0);
        check("start_vez_ativa", {3'b000, vez_ativa}, 4'd1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        model_primeiro = 1'b0;
        @(negedge clock);
        check("rst_jogador", {2'b00, jogador}, 4'd0);
        check("rst_timeout", {3'b000, timeout}, 4'd0);
        check("rst_vez_ativa", {3'b000, vez_ativa}, 4'd0);
        check("rst_jogadas", jogadas, 4'd0);
        reset = 1'b1;
        tick();
    endtask

    task automatic move(input logic fj);
        jogada = 1'b1;
        fim_jogo = fj;
        tick();
        jogada = 1'b0;
        fim_jogo = 1'b0;
    endtask

    initial begin
        // full game of 9 moves
        do_reset();
        start_game(code);
        cur = code;
        for (int i = 1; i <= 9; i++) begin
            repeat (2) tick();
            move(1'b0);
            check("g9_jogadas", jogadas, 4'(i));
            check("g9_timeout", {3'b000, timeout}, 4'd0);
            if (i < 9) cur = ~cur;
            check("g9_jogador", {2'b00, jogador}, {2'b00, cur});
        end
        check("g9_fim_jogador", {2'b00, jogador}, 4'd1);
        check("g9_fim_vez_ativa", {3'b000, vez_ativa}, 4'd0);

        // timeout with no moves
        do_reset();
        start_game(code);
        repeat (9) tick();
        check("to_before_jogador", {2'b00, jogador}, 4'd1);
        check("to_before_timeout", {3'b000, timeout}, 4'd0);
        tick();
        check("to_jogador", {2'b00, jogador}, 4'd3);
        check("to_pulse", {3'b000, timeout}, 4'd1);
        check("to_vez_ativa", {3'b000, vez_ativa}, 4'd0);
        tick();
        check("to_pulse_end", {3'b000, timeout}, 4'd0);
        check("to_hold", {2'b00, jogador}, 4'd3);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        move(1'b0);
        check("erro_ignores_jogador", {2'b00, jogador}, 4'd3);
        reconhece = 1'b1;
        tick();
        reconhece = 1'b0;
        check("rec_jogador", {2'b00, jogador}, 4'd0);
        check("rec_jogadas", jogadas, 4'd0);
        move(1'b0);
        check("ocioso_jogada_jogador", {2'b00, jogador}, 4'd0);
        check("ocioso_jogada_jogadas", jogadas, 4'd0);

        // move at the last allowed cycle wins over timeout
        do_reset();
        start_game(code);
        repeat (9) tick();
        move(1'b0);
        check("edge_jogador", {2'b00, jogador}, 4'd2);
        check("edge_timeout", {3'b000, timeout}, 4'd0);
        check("edge_jogadas", jogadas, 4'd1);
        tick();
        check("edge_after", {2'b00, jogador}, 4'd2);

        // win on the 5th move
        do_reset();
        start_game(code);
        repeat (4) begin
            tick();
            move(1'b0);
        end
        check("win4_jogador", {2'b00, jogador}, 4'd1);
        move(1'b1);
        check("win_jogador", {2'b00, jogador}, 4'd1);
        check("win_jogadas", jogadas, 4'd5);
        check("win_vez_ativa", {3'b000, vez_ativa}, 4'd0);
        move(1'b1);
        check("fim_ignores_jogador", {2'b00, jogador}, 4'd1);
        check("fim_ignores_jogadas", jogadas, 4'd5);

        // fim_jogo without a move, then restart mid-turn
        start_game(code);
        fim_jogo = 1'b1;
        tick();
        fim_jogo = 1'b0;
        check("fimonly_jogador", {2'b00, jogador}, {2'b00, code});
        check("fimonly_vez_ativa", {3'b000, vez_ativa}, 4'd0);
        start_game(code);
        move(1'b0);
        check("restart_pre_jogadas", jogadas, 4'd1);
        start_game(code);

        // async reset mid-VEZ2
        do_reset();
        start_game(code);
        move(1'b0);
        check("mid_jogador", {2'b00, jogador}, 4'd2);
        #2;
        reset = 1'b0;
        model_primeiro = 1'b0;
        #1;
        check("async_jogador", {2'b00, jogador}, 4'd0);
        check("async_vez_ativa", {3'b000, vez_ativa}, 4'd0);
        check("async_jogadas", jogadas, 4'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // starting player across games and across reset
        start_game(code);
        check("alt_g1", {2'b00, code}, 4'd1);
        start_game(code);
`ifdef ALTERNA_INICIO_EN
        check("alt_g2", {2'b00, jogador}, 4'd2);
`else
        check("alt_g2", {2'b00, jogador}, 4'd1);
`endif
        do_reset();
        start_game(code);
        check("alt_after_rst", {2'b00, jogador}, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
